// File: rtl/next_state_sequencer_pkg.sv
// Shared control-unit definitions: microstate width and the control-word
// field encodings used by the next-state sequencer.
package next_state_sequencer_pkg;

    localparam int STATE_W = 10;

    typedef enum logic [2:0] {
        NS_INCR   = 3'd0,
        NS_JUMP   = 3'd1,
        NS_DECODE = 3'd2,
        NS_CJUMP  = 3'd3,
        NS_WAIT   = 3'd4,
        NS_CALL   = 3'd5,
        NS_RETURN = 3'd6,
        NS_FETCH  = 3'd7
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'd0,
        CS_Z    = 2'd1,
        CS_COND = 2'd2,
        CS_TRUE = 2'd3
    } cond_sel_e;

endpackage

// File: rtl/next_state_sequencer_cond.sv
// Condition selector for the microsequencer: picks one status source by
// cond_sel and applies the invert bit, producing the branch condition c.
module microsequencer_cond (
    input  logic [1:0] cond_sel,
    input  logic       inv,
    input  logic       moc,
    input  logic       z_flag,
    input  logic       cond_in,
    output logic       c
);
    import next_state_sequencer_pkg::*;

    logic sel_s;

    // Status-source multiplexer.
    always_comb begin
        sel_s = 1'b1;
        case (cond_sel_e'(cond_sel))
            CS_MOC:  sel_s = moc;
            CS_Z:    sel_s = z_flag;
            CS_COND: sel_s = cond_in;
            CS_TRUE: sel_s = 1'b1;
            default: sel_s = 1'b1;
        endcase
    end

    assign c = sel_s ^ inv;

endmodule

// File: rtl/next_state_sequencer.sv
// Microprogram sequencer: selects the next microstore address from the
// control word, decoder start address and status, with a bounded WAIT stall.
module next_state_sequencer #(
    parameter int STATE_W    = next_state_sequencer_pkg::STATE_W,
    parameter int WAIT_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_sel,
    input  logic [1:0]         cond_sel,
    input  logic               inv,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic [STATE_W-1:0] decode_addr,
    input  logic               moc,
    input  logic               z_flag,
    input  logic               cond_in,
    output logic [STATE_W-1:0] next_state,
    output logic [STATE_W-1:0] current_state,
    output logic               timeout
);
    import next_state_sequencer_pkg::*;

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

    logic [STATE_W-1:0] current_state_r;
    logic [STATE_W-1:0] ret_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [STATE_W-1:0] inc_s;
    logic [STATE_W-1:0] mux_s;
    logic [STATE_W-1:0] next_s;
    logic               c_s;
    logic               stall_s;
    logic               limit_hit_s;
    logic               timeout_s;

    microsequencer_cond u_cond (
        .cond_sel (cond_sel),
        .inv      (inv),
        .moc      (moc),
        .z_flag   (z_flag),
        .cond_in  (cond_in),
        .c        (c_s)
    );

    assign inc_s       = current_state_r + STATE_W'(1);
    assign stall_s     = (ns_sel_e'(ns_sel) == NS_WAIT) && !c_s;
    assign limit_hit_s = stall_s && (wait_cnt_r == LIMIT_C);

    // Address selection from the control word's next-state field.
    always_comb begin
        mux_s = inc_s;
        case (ns_sel_e'(ns_sel))
            NS_INCR:   mux_s = inc_s;
            NS_JUMP:   mux_s = cr_addr;
            NS_DECODE: mux_s = decode_addr;
            NS_CJUMP:  mux_s = c_s ? cr_addr : inc_s;
            NS_WAIT:   mux_s = c_s ? inc_s : current_state_r;
            NS_CALL:   mux_s = cr_addr;
            NS_RETURN: mux_s = ret_r;
            NS_FETCH:  mux_s = {STATE_W{1'b0}};
            default:   mux_s = inc_s;
        endcase
    end

    // Reset forces address 0; a stall at the limit escapes to cr_addr.
    always_comb begin
        next_s    = mux_s;
        timeout_s = 1'b0;
        if (reset) begin
            next_s    = {STATE_W{1'b0}};
            timeout_s = 1'b0;
        end else if (limit_hit_s) begin
            next_s    = cr_addr;
            timeout_s = 1'b1;
        end else begin
            next_s    = mux_s;
            timeout_s = 1'b0;
        end
    end

    // State, return register and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_state_r <= {STATE_W{1'b0}};
            ret_r           <= {STATE_W{1'b0}};
            wait_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            current_state_r <= next_s;
            if (ns_sel_e'(ns_sel) == NS_CALL) begin
                ret_r <= inc_s;
            end else begin
                ret_r <= ret_r;
            end
            if (stall_s && !limit_hit_s) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign next_state    = next_s;
    assign current_state = current_state_r;
    assign timeout       = timeout_s;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Self-checking bench for next_state_sequencer: directed scenarios followed by
// random control words, all compared against an integer-level reference model.
module tb_next_state_sequencer;

    localparam int SW    = 10;
    localparam int LIMIT = 4;

    logic          clk;
    logic          reset;
    logic [2:0]    ns_sel;
    logic [1:0]    cond_sel;
    logic          inv;
    logic [SW-1:0] cr_addr;
    logic [SW-1:0] decode_addr;
    logic          moc;
    logic          z_flag;
    logic          cond_in;
    logic [SW-1:0] next_state;
    logic [SW-1:0] current_state;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers.
    int m_cur = 0;
    int m_ret = 0;
    int m_stalls = 0;

    next_state_sequencer #(.STATE_W(SW), .WAIT_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ns_sel        (ns_sel),
        .cond_sel      (cond_sel),
        .inv           (inv),
        .cr_addr       (cr_addr),
        .decode_addr   (decode_addr),
        .moc           (moc),
        .z_flag        (z_flag),
        .cond_in       (cond_in),
        .next_state    (next_state),
        .current_state (current_state),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Asynchronous reset: outputs clear before any edge, then release.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_cur_async", {22'd0, current_state}, 32'd0);
        check("reset_next_async", {22'd0, next_state}, 32'd0);
        check("reset_timeout", {31'd0, timeout}, 32'd0);
        @(posedge clk);
        #1;
        check("reset_cur_held", {22'd0, current_state}, 32'd0);
        reset = 1'b0;
        m_cur = 0;
        m_ret = 0;
        m_stalls = 0;
    endtask

    // One microcycle: drive a control word, check the combinational outputs,
    // clock it, and check the new current_state.
    task automatic step(input int ns, input int cs, input int iv, input int cr,
                        input int dec, input int mo, input int z, input int ci);
        int  src[4];
        int  c;
        int  incv;
        int  exp;
        bit  stall;
        bit  to;
        ns_sel      = 3'(ns);
        cond_sel    = 2'(cs);
        inv         = 1'(iv);
        cr_addr     = 10'(cr);
        decode_addr = 10'(dec);
        moc         = 1'(mo);
        z_flag      = 1'(z);
        cond_in     = 1'(ci);
        #1;
        src  = '{mo, z, ci, 1};
        c    = src[cs] ^ iv;
        incv = (m_cur + 1) % 1024;
        case (ns)
            0:       exp = incv;
            1:       exp = cr;
            2:       exp = dec;
            3:       exp = (c != 0) ? cr : incv;
            4:       exp = (c != 0) ? incv : m_cur;
            5:       exp = cr;
            6:       exp = m_ret;
            default: exp = 0;
        endcase
        stall = (ns == 4) && (c == 0);
        to    = stall && (m_stalls == LIMIT);
        if (to) exp = cr;
        check("next_state", {22'd0, next_state}, 32'(exp));
        check("timeout", {31'd0, timeout}, {31'd0, to});
        @(posedge clk);
        #1;
        if (ns == 5) m_ret = incv;
        m_stalls = (stall && !to) ? m_stalls + 1 : 0;
        m_cur = exp;
        check("current_state", {22'd0, current_state}, 32'(m_cur));
    endtask

    initial begin
        int ns, cs, burst;
        reset = 1'b1;
        ns_sel = 3'd0; cond_sel = 2'd0; inv = 1'b0; cr_addr = 10'd0;
        decode_addr = 10'd0; moc = 1'b0; z_flag = 1'b0; cond_in = 1'b0;
        do_reset();

        // Reset mid-run at state 37, then count 0, 1, 2.
        step(1, 0, 0, 37, 0, 0, 0, 0);
        check("at_37", {22'd0, current_state}, 32'd37);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("run_to_2", {22'd0, current_state}, 32'd2);

        // DECODE, JUMP, FETCH.
        step(2, 0, 0, 0, 20, 0, 0, 0);
        step(1, 0, 0, 41, 0, 0, 0, 0);
        step(7, 0, 0, 5, 9, 0, 0, 0);

        // CJUMP on Z with both polarities from state 22.
        step(1, 0, 0, 22, 0, 0, 0, 0);
        step(3, 1, 0, 26, 0, 0, 1, 0);
        check("cjump_taken", {22'd0, current_state}, 32'd26);
        step(1, 0, 0, 22, 0, 0, 0, 0);
        step(3, 1, 1, 26, 0, 0, 1, 0);
        check("cjump_inverted", {22'd0, current_state}, 32'd23);

        // WAIT on MOC below the limit, then advance.
        step(1, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) step(4, 0, 0, 42, 0, 0, 0, 0);
        step(4, 0, 0, 42, 0, 1, 0, 0);
        check("wait_advance", {22'd0, current_state}, 32'd4);

        // Timeout on stall cycle LIMIT+1.
        step(1, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) step(4, 0, 0, 42, 0, 0, 0, 0);
        ns_sel = 3'd4; cond_sel = 2'd0; moc = 1'b0; cr_addr = 10'd42;
        #1;
        check("timeout_pulse", {31'd0, timeout}, 32'd1);
        step(4, 0, 0, 42, 0, 0, 0, 0);
        check("timeout_dest", {22'd0, current_state}, 32'd42);

        // moc rising in the limit cycle: advance wins, no timeout.
        step(1, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) step(4, 0, 0, 42, 0, 0, 0, 0);
        step(4, 0, 0, 42, 0, 1, 0, 0);
        check("limit_advance", {22'd0, current_state}, 32'd4);

        // CALL/RETURN and wrap.
        step(1, 0, 0, 12, 0, 0, 0, 0);
        step(5, 0, 0, 40, 0, 0, 0, 0);
        step(6, 0, 0, 0, 0, 0, 0, 0);
        check("return_addr", {22'd0, current_state}, 32'd13);
        step(1, 0, 0, 1023, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("wrap", {22'd0, current_state}, 32'd0);

        // Reset in the middle of a WAIT after a CALL.
        step(5, 0, 0, 100, 0, 0, 0, 0);
        step(4, 0, 0, 7, 0, 0, 0, 0);
        step(4, 0, 0, 7, 0, 0, 0, 0);
        do_reset();
        step(6, 0, 0, 0, 0, 0, 0, 0);
        check("ret_cleared", {22'd0, current_state}, 32'd0);

        // Random control words with occasional long MOC stalls and resets.
        burst = 0;
        for (int i = 0; i < 500; i++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(3, 8);
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else if (burst > 0) begin
                burst--;
                step(4, 0, 0, $urandom_range(0, 1023), 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
                     $urandom_range(0, 1), $urandom_range(0, 1));
            end else begin
                ns = $urandom_range(0, 9);
                if (ns > 7) ns = 4;
                cs = $urandom_range(0, 3);
                step(ns, cs, $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_state_sequencer.md
# next_state_sequencer

Microprogram sequencer for the control unit. Holds the current microstate and computes the 10-bit `next_state` address that drives the microstore. The selection is made from the fields of the current control word, the instruction-decoder start address and the status conditions. Sits directly upstream of the microstore; the control register downstream of the microstore latches the resulting control word on the same edge that this block updates `current_state`.

## Interface
Parameters:
- `STATE_W`, default 10: microstate address width; must match the microstore address.
- `WAIT_LIMIT`, default 255: maximum consecutive stall cycles in WAIT before a forced escape.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: reset, asynchronous and active-high.
- `ns_sel`, input, 3: next-state select field of the current control word.
- `cond_sel`, input, 2: condition-source select field.
- `inv`, input, 1: condition invert bit.
- `cr_addr`, input, STATE_W: target-address field of the current control word.
- `decode_addr`, input, STATE_W: start address of the instruction's microroutine, from the instruction encoder.
- `moc`, input, 1: memory operation complete.
- `z_flag`, input, 1: ALU zero flag.
- `cond_in`, input, 1: result from the condition tester.
- `next_state`, output, STATE_W: combinational address to the microstore.
- `current_state`, output, STATE_W: registered current microstate.
- `timeout`, output, 1: one-cycle pulse when a WAIT escape occurs.

## Operation
- Selected condition `c` = (`moc`, `z_flag`, `cond_in`, 1'b1 for `cond_sel` 0..3) XOR `inv`.
- `inc` = `current_state` + 1, truncated to STATE_W; 1023 + 1 wraps to 0.
- `ns_sel` encoding and resulting `next_state`:
  - 0 INCR: `inc`.
  - 1 JUMP: `cr_addr`.
  - 2 DECODE: `decode_addr`.
  - 3 CJUMP: `c` ? `cr_addr` : `inc`.
  - 4 WAIT: `c` ? `inc` : `current_state`. This is the stall mode.
  - 5 CALL: `cr_addr`; the return register `ret` is loaded with `inc`.
  - 6 RETURN: `ret`.
  - 7 FETCH: 0.
- `ret` is a one-level return register. A CALL while a call is already active overwrites it; there is no nesting and no error.
- `wait_cnt` counts consecutive stall cycles in WAIT with `c` = 0.
  - It clears on any cycle that is not a stall.
  - When `wait_cnt` == WAIT_LIMIT and the cycle is still a stall, `next_state` = `cr_addr`, `timeout` = 1 for that cycle, and `wait_cnt` clears on the edge.
- `current_state` <= `next_state` on every rising edge.
- While `reset` is high, `next_state` is forced to 0 combinationally, so the microstore presents state 0.
- Reset values: `current_state` = 0, `ret` = 0, `wait_cnt` = 0, `timeout` = 0.
- Reset asserted mid-operation, including mid-WAIT or after a CALL: all registers clear immediately, with no dependence on the clock. The first edge after deassertion loads the state computed from state 0's control word.

## Timing
- `next_state` and `timeout` are combinational from registered state and inputs, with zero latency. There must be no combinational path from `next_state` back into its own select inputs inside this block.
- One microstate per clock, except in WAIT: while `c` = 0 the state holds. It advances on the edge after `c` goes to 1, or escapes on stall cycle WAIT_LIMIT+1.
- `ret` is written on the same edge that `current_state` takes `cr_addr` for a CALL. A RETURN in the very next state reads the new value.
- `wait_cnt` saturation is exact: with WAIT_LIMIT = 255 and `c` held at 0, `timeout` asserts during the 256th stall cycle.
- Simultaneous events:
  - If `c` rises during the limit cycle, the advance wins (`inc`) and there is no `timeout`.
  - If `reset` is high, it overrides every other condition.

## Structure
- Shared control-unit package holds:
  - `STATE_W`.
  - The `ns_sel` encodings (NS_INCR, NS_JUMP, NS_DECODE, NS_CJUMP, NS_WAIT, NS_CALL, NS_RETURN, NS_FETCH).
  - The `cond_sel` encodings (CS_MOC, CS_Z, CS_COND, CS_TRUE).
- One natural sub-module, `microsequencer_cond`: the combinational condition mux plus invert, producing `c`.
- The address mux, state register, `ret` and `wait_cnt` stay in this block.

## Test plan
- Reset: assert `reset` mid-run at `current_state` = 37 → `current_state` = 0 and `next_state` = 0 immediately, without a clock edge. After release with `ns_sel` = INCR, the states run 0, 1, 2.
- DECODE and JUMP:
  - From state 2 with `ns_sel` = DECODE and `decode_addr` = 20 → next state 20.
  - Then `ns_sel` = JUMP with `cr_addr` = 41 → next state 41.
  - Then FETCH → next state 0.
- CJUMP polarity: `cond_sel` = Z, `z_flag` = 1, `cr_addr` = 26 at state 22.
  - With `inv` = 0 → next state 26.
  - With `inv` = 1 → next state 23.
- WAIT on MOC: state 3 with `ns_sel` = WAIT and `cond_sel` = MOC, `moc` low for 5 cycles → `current_state` stays 3 for 5 cycles. It becomes 4 on the edge after `moc` = 1, and `timeout` never asserts.
- Timeout (WAIT_LIMIT = 4): `moc` held at 0, `cr_addr` = 42 → `timeout` pulses on the 5th stall cycle, and `current_state` = 42 on the next edge.
  - Repeat with `moc` rising exactly in the 5th stall cycle → next state 4, no `timeout`.
- CALL/RETURN and wrap:
  - CALL at state 12 with `cr_addr` = 40, then RETURN at state 40 → next state 13.
  - INCR at state 1023 → next state 0.
